// File: rtl/encoder_speed_meas_if.sv
// rtl/encoder_speed_meas_if.sv - encoder strobe inputs and speed-loop feedback bundle
interface encoder_speed_meas_if;
    logic               enc_pulse;
    logic [1:0]         enc_dir;
    logic signed [15:0] pulse_cnt;
    logic signed [15:0] speed_rpm;
    logic               speed_valid;
    logic               busy;
    logic               cnt_sat;
    logic               stall;

    // master: the side feeding pulses and consuming the speed feedback
    modport master (
        output enc_pulse, enc_dir,
        input  pulse_cnt, speed_rpm, speed_valid, busy, cnt_sat, stall
    );

    // slave: the speed measurement block
    modport slave (
        input  enc_pulse, enc_dir,
        output pulse_cnt, speed_rpm, speed_valid, busy, cnt_sat, stall
    );
endinterface

// File: rtl/encoder_speed_meas.sv
// rtl/encoder_speed_meas.sv - M-method encoder speed measurement (optional SPEED_FILTER_EN 4-window average)
module encoder_speed_meas #(
    parameter int CLK_FREQ_KHZ = 50000,
    parameter int GATE_MS      = 10,
    parameter int ENCO_NUM     = 4000,
    parameter int STALL_WIN    = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_speed_meas_if.slave  bus
);
    localparam int GATE_CYCLES = CLK_FREQ_KHZ * GATE_MS;
`ifdef SPEED_FILTER_EN
    localparam int NW        = 35;
    localparam int DEN_SCALE = 4;
`else
    localparam int NW        = 32;
    localparam int DEN_SCALE = 1;
`endif
    localparam logic [31:0]        DEN       = 32'(ENCO_NUM * GATE_MS * DEN_SCALE);
    localparam logic [31:0]        GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic signed [16:0] ACC_MAX   = 17'sd32767;
    localparam logic signed [16:0] ACC_MIN   = -17'sd32767;
    localparam int                 SW        = $clog2(STALL_WIN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        gate_cnt;
    logic               win_end;
    logic               fwd, rev;
    logic signed [16:0] acc;
    logic               sat;
    logic signed [15:0] cnt_q;
    logic               cnt_sat_q;
    logic signed [17:0] load_val;
    logic [17:0]        mag;
    logic [NW-1:0]      num_load;
    logic [NW-1:0]      quo;
    logic [31:0]        rem;
    logic [32:0]        trial;
    logic               ge;
    logic [31:0]        rem_nxt;
    logic [5:0]         div_cnt;
    logic               neg;
    logic signed [15:0] clamped;
    logic signed [15:0] rpm_new;
    logic signed [15:0] rpm_q;
    logic [SW-1:0]      stall_cnt;
    logic [SW-1:0]      stall_cnt_nxt;
    logic               stall_nxt;
    logic               stall_q;

    assign win_end = (gate_cnt == GATE_LAST);
    assign fwd     = bus.enc_pulse && (bus.enc_dir == 2'b10);
    assign rev     = bus.enc_pulse && (bus.enc_dir == 2'b01);

    // free-running gate window counter
    always_ff @(posedge clk) begin
        if (rst)          gate_cnt <= '0;
        else if (win_end) gate_cnt <= '0;
        else              gate_cnt <= gate_cnt + 32'd1;
    end

    // signed pulse accumulator; a pulse on the terminal cycle seeds the next window
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (win_end) begin
            acc <= fwd ? 17'sd1 : (rev ? -17'sd1 : 17'sd0);
            sat <= 1'b0;
        end else if (fwd) begin
            if (acc == ACC_MAX) sat <= 1'b1;
            else                acc <= acc + 17'sd1;
        end else if (rev) begin
            if (acc == ACC_MIN) sat <= 1'b1;
            else                acc <= acc - 17'sd1;
        end
    end

    // latch the completed window count and its saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            cnt_sat_q <= 1'b0;
        end else if (win_end) begin
            cnt_q     <= acc[15:0];
            cnt_sat_q <= sat;
        end
    end

`ifdef SPEED_FILTER_EN
    logic signed [15:0] hist [4];

    // shift register of the last four window counts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else if (win_end) begin
            hist[0] <= acc[15:0];
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    assign load_val = {{2{hist[0][15]}}, hist[0]} + {{2{hist[1][15]}}, hist[1]}
                    + {{2{hist[2][15]}}, hist[2]} + {{2{hist[3][15]}}, hist[3]};
`else
    assign load_val = {{2{cnt_q[15]}}, cnt_q};
`endif

    assign mag      = load_val[17] ? 18'(-load_val) : 18'(load_val);
    assign num_load = NW'(mag) * NW'(60000);

    // one restoring-division step: shift in the next dividend bit, subtract if it fits
    assign trial   = {rem, quo[NW-1]};
    assign ge      = (trial >= {1'b0, DEN});
    assign rem_nxt = ge ? 32'(trial - {1'b0, DEN}) : trial[31:0];

    // sign restore and clamp of the finished quotient
    assign clamped = (quo > NW'(32767)) ? 16'sd32767 : $signed(quo[15:0]);
    assign rpm_new = neg ? -clamped : clamped;

    // stall counter saturates at STALL_WIN on consecutive empty windows
    assign stall_cnt_nxt = (cnt_q != 16'sd0) ? '0 :
                           ((stall_cnt == SW'(STALL_WIN)) ? stall_cnt : stall_cnt + 1'b1);
    assign stall_nxt     = (stall_cnt_nxt == SW'(STALL_WIN));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_end) state_nxt = LOAD;
            LOAD:    state_nxt = DIV;
            DIV:     if (div_cnt == 6'(NW - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // divider datapath: load operands, then iterate one quotient bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            quo     <= '0;
            rem     <= '0;
            neg     <= 1'b0;
            div_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    quo     <= num_load;
                    rem     <= '0;
                    neg     <= load_val[17];
                    div_cnt <= '0;
                end
                DIV: begin
                    quo     <= {quo[NW-2:0], ge};
                    rem     <= rem_nxt;
                    div_cnt <= div_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // hold the published speed and stall state between updates
    always_ff @(posedge clk) begin
        if (rst) begin
            rpm_q     <= '0;
            stall_cnt <= '0;
            stall_q   <= 1'b0;
        end else if (state == DONE) begin
            rpm_q     <= rpm_new;
            stall_cnt <= stall_cnt_nxt;
            stall_q   <= stall_nxt;
        end
    end

    // FSM outputs: the new speed and stall are visible in the same cycle as speed_valid
    always_comb begin
        bus.speed_valid = (state == DONE);
        bus.busy        = (state != IDLE);
        bus.speed_rpm   = (state == DONE) ? rpm_new : rpm_q;
        bus.stall       = (state == DONE) ? stall_nxt : stall_q;
        bus.pulse_cnt   = cnt_q;
        bus.cnt_sat     = cnt_sat_q;
    end

    // a window must never close while the divider is still working
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(win_end && (state != IDLE)));

endmodule
